sha256_compress_engine: RTL and testbench

//  Self-sequencing SHA-256 compression core. Holds the 8-word hash state and runs 64 rounds,

---
 rtl/sha256_compress_engine.sv | 150 +++++++++++++++
 tb/tb_sha256_compress_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_compress_engine.sv
// SHA-256 compression core: holds the chaining state, runs ROUNDS_PER_CYCLE rounds
// per accepted schedule beat, applies feed-forward and serves the digest by address.
module sha256_compress_engine #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int FEED_FORWARD     = 1,
  parameter int OUT_WORDS        = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init_we,
  input  logic [2:0]                     init_addr,
  input  logic [31:0]                    init_data,
  input  logic                           start,
  output logic                           busy,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [32*ROUNDS_PER_CYCLE-1:0] w_data,
  output logic                           done,
  input  logic [2:0]                     dout_addr,
  output logic [31:0]                    dout_data,
  output logic                           dout_valid
);

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  state_t           state, state_next;
  logic [6:0]       cnt, cnt_plus;
  logic [7:0][31:0] wk, wk_round, h, h_next;
  logic             idle_like, xfer, last_beat;
  logic [31:0]      rd_word;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  // Unrolled rounds are evaluated in sequence inside one combinational cloud;
  // word 0 is A and word 7 is H.
  function automatic logic [7:0][31:0] do_rounds(input logic [7:0][31:0]            s_in,
                                                 input logic [5:0]                  base,
                                                 input logic [32*ROUNDS_PER_CYCLE-1:0] w);
    logic [7:0][31:0] s;
    logic [31:0]      t1, t2;
    s = s_in;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      t1 = s[7] + big_sigma1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6]))
         + K[base + 6'(j)] + w[32*j +: 32];
      t2 = big_sigma0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6];
      s[6] = s[5];
      s[5] = s[4];
      s[4] = s[3] + t1;
      s[3] = s[2];
      s[2] = s[1];
      s[1] = s[0];
      s[0] = t1 + t2;
    end
    return s;
  endfunction

  assign idle_like = (state == IDLE) || (state == DONE);
  assign xfer      = (state == RUN) && w_valid;
  assign cnt_plus  = cnt + 7'(ROUNDS_PER_CYCLE);
  assign last_beat = (cnt_plus == 7'd64);
  assign wk_round  = do_rounds(wk, cnt[5:0], w_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    w_ready    = 1'b0;
    dout_valid = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy    = 1'b1;
        w_ready = 1'b1;
        if (xfer && last_beat) state_next = FINAL;
      end
      FINAL: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        dout_valid = 1'b1;
        if (start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // The read port samples the post-update hash so the digest is visible in the first DONE cycle.
  always_comb begin
    h_next = h;
    if (state == FINAL) begin
      for (int i = 0; i < 8; i++)
        h_next[i] = (FEED_FORWARD != 0) ? h[i] + wk[i] : wk[i];
    end else if (idle_like && init_we) begin
      h_next[init_addr] = init_data;
    end
    rd_word = ({29'd0, dout_addr} < 32'(OUT_WORDS)) ? h_next[dout_addr] : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 7'd0;
      wk        <= '0;
      h         <= IV;
      done      <= 1'b0;
      dout_data <= 32'd0;
    end else begin
      h         <= h_next;
      done      <= (state == FINAL);
      dout_data <= rd_word;
      if (idle_like && start) begin
        wk  <= h;
        cnt <= 7'd0;
      end else if (xfer) begin
        wk  <= wk_round;
        cnt <= cnt_plus;
      end
    end
  end

endmodule

// File: tb/tb_sha256_compress_engine.sv
// Directed bench for sha256_compress_engine: known-answer digests, stalls, abort,
// ignored controls, and a 4-round / no-feed-forward / SHA-224-width variant.
module tb_sha256_compress_engine;

  localparam logic [7:0][31:0] IV_D = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [7:0][31:0] ABC_D = {
    32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
    32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam logic [7:0][31:0] TWO_D = {
    32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
    32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};

  logic         clk = 1'b0;
  logic         rst_n, init_we, start, w_valid;
  logic [2:0]   init_addr, dout_addr;
  logic [31:0]  init_data, w_data;
  logic [127:0] w_data4;
  logic         busy, w_ready, done, dout_valid;
  logic [31:0]  dout_data;
  logic         busy4, w_ready4, done4, dout_valid4;
  logic [31:0]  dout_data4;

  logic [31:0]      wsch [64];
  logic [15:0][31:0] msg;
  logic [7:0][31:0]  exp4;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sha256_compress_engine dut (
    .clk(clk), .rst_n(rst_n), .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .start(start), .busy(busy), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .done(done), .dout_addr(dout_addr), .dout_data(dout_data), .dout_valid(dout_valid));

  sha256_compress_engine #(.ROUNDS_PER_CYCLE(4), .FEED_FORWARD(0), .OUT_WORDS(7)) dut4 (
    .clk(clk), .rst_n(rst_n), .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .start(start), .busy(busy4), .w_valid(w_valid), .w_ready(w_ready4), .w_data(w_data4),
    .done(done4), .dout_addr(dout_addr), .dout_data(dout_data4), .dout_valid(dout_valid4));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed still running, required finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Standard SHA-256 message schedule, built here so the DUT only sees W.
  task automatic expand(input logic [15:0][31:0] m);
    for (int t = 0; t < 16; t++) wsch[t] = m[t];
    for (int t = 16; t < 64; t++)
      wsch[t] = (rr(wsch[t-2], 17) ^ rr(wsch[t-2], 19) ^ (wsch[t-2] >> 10)) + wsch[t-7]
              + (rr(wsch[t-15], 7) ^ rr(wsch[t-15], 18) ^ (wsch[t-15] >> 3)) + wsch[t-16];
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_w_ready", w_ready, 1);
  endtask

  task automatic feed(input int n, input bit gaps, input int poke_at);
    int lowready;
    lowready = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        w_valid = 1'b0;
        w_data  = $urandom;
        repeat ($urandom_range(1, 10)) tick();
        check($sformatf("gap_cnt_%0d", k), 32'(dut.cnt), k);
        check($sformatf("gap_ready_%0d", k), w_ready, 1);
      end
      w_valid = 1'b1;
      w_data  = wsch[k];
      w_data4 = (k < 16) ? {wsch[4*k+3], wsch[4*k+2], wsch[4*k+1], wsch[4*k]} : 128'd0;
      if (k == poke_at) begin
        init_we   = 1'b1;
        init_addr = 3'd3;
        init_data = 32'hffffffff;
        start     = 1'b1;
      end
      if (!w_ready) lowready++;
      tick();
      init_we = 1'b0;
      start   = 1'b0;
    end
    w_valid = 1'b0;
    check("ready_low_beats", lowready, 0);
  endtask

  task automatic finish_block();
    check("final_done", done, 0);
    check("final_busy", busy, 1);
    tick();
    check("done_pulse", done, 1);
    check("done_dvalid", dout_valid, 1);
    check("done_busy", busy, 0);
    tick();
    check("done_drop", done, 0);
  endtask

  task automatic read_dig(input string tag, input logic [7:0][31:0] expd);
    for (int i = 0; i < 8; i++) begin
      dout_addr = 3'(i);
      tick();
      check($sformatf("%s_h%0d", tag, i), dout_data, expd[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; init_we = 1'b0; init_addr = 3'd0; init_data = 32'd0; start = 1'b0;
    w_valid = 1'b0; w_data = 32'd0; w_data4 = 128'd0; dout_addr = 3'd0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_done", done, 0);
    check("rst_dvalid", dout_valid, 0);
    check("rst_dout", dout_data, 0);
    rst_n = 1'b1;
    tick();
    read_dig("iv", IV_D);

    // Four rounds per beat, no feed-forward, seven readable words.
    msg = '0; msg[0] = 32'h61626380; msg[15] = 32'h00000018;
    expand(msg);
    do_start();
    check("rpc4_busy", busy4, 1);
    feed(16, 1'b0, -1);
    check("rpc4_final_done", done4, 0);
    tick();
    check("rpc4_done", done4, 1);
    check("rpc4_dvalid", dout_valid4, 1);
    for (int i = 0; i < 8; i++) exp4[i] = (i < 7) ? ABC_D[i] - IV_D[i] : 32'd0;
    for (int i = 0; i < 8; i++) begin
      dout_addr = 3'(i);
      tick();
      check($sformatf("rpc4_h%0d", i), dout_data4, exp4[i]);
    end

    // Single block "abc".
    reset_pulse();
    do_start();
    feed(64, 1'b0, -1);
    finish_block();
    read_dig("abc", ABC_D);

    // Two chained blocks.
    reset_pulse();
    for (int t = 0; t < 14; t++) msg[t] = {8'(97 + t), 8'(98 + t), 8'(99 + t), 8'(100 + t)};
    msg[14] = 32'h80000000; msg[15] = 32'h0;
    expand(msg);
    do_start();
    feed(64, 1'b0, -1);
    finish_block();
    msg = '0; msg[15] = 32'h000001c0;
    expand(msg);
    do_start();
    feed(64, 1'b0, -1);
    finish_block();
    read_dig("two", TWO_D);

    // "abc" with random stalls.
    msg = '0; msg[0] = 32'h61626380; msg[15] = 32'h00000018;
    expand(msg);
    reset_pulse();
    do_start();
    feed(64, 1'b1, -1);
    finish_block();
    read_dig("gaps", ABC_D);

    // Abort at beat 30, then rerun.
    reset_pulse();
    do_start();
    feed(30, 1'b0, -1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_w_ready", w_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    read_dig("abort_iv", IV_D);
    do_start();
    feed(64, 1'b0, -1);
    finish_block();
    read_dig("rerun", ABC_D);

    // init_we and start during RUN are ignored; init_we in IDLE lands.
    reset_pulse();
    do_start();
    feed(64, 1'b0, 10);
    finish_block();
    read_dig("poke", ABC_D);
    reset_pulse();
    init_we = 1'b1; init_addr = 3'd3; init_data = 32'hffffffff;
    tick();
    init_we = 1'b0;
    dout_addr = 3'd3;
    tick();
    check("init_h3", dout_data, 32'hffffffff);
    dout_addr = 3'd2;
    tick();
    check("init_h2", dout_data, IV_D[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
